pi_ctl_slew_limiter: RTL and testbench

Sits between the CDR/offset/scaling path that produces the per-channel PI control codes and the analog phase-interpolator inputs. Rate-limits every code change so the PI never jumps by more than a programmed step per update interval. Code movement uses modular (wrap-around) shortest-path arithmetic, so the PI phase never sweeps the long way around. JTAG provides enable, step size, hold interval and a direct-load pulse.

---
 rtl/pi_ctl_slew_limiter_if.sv | 32 +++
 rtl/pi_ctl_slew_limiter.sv | 93 +++++++++
 tb/tb_pi_ctl_slew_limiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pi_ctl_slew_limiter_if.sv
`default_nettype none
// ============================================================================
// Module      : pi_ctl_slew_limiter_if
// Description : Control-code, configuration and status bundle between the
//               PI code source and the per-channel slew limiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface pi_ctl_slew_limiter_if #(
   parameter int NPI   = 9,
   parameter int NOUT  = 4,
   parameter int NHOLD = 4
);
   logic [NPI-1:0]   pi_ctl_target [NOUT];
   logic             en_limit;
   logic [NPI-1:0]   max_step;
   logic [NHOLD-1:0] hold_cycles;
   logic             load_direct;
   logic [NPI-1:0]   pi_ctl_out    [NOUT];
   logic [NOUT-1:0]  settled;
   logic             busy;

   modport master (
      output pi_ctl_target, en_limit, max_step, hold_cycles, load_direct,
      input  pi_ctl_out, settled, busy
   );

   modport slave (
      input  pi_ctl_target, en_limit, max_step, hold_cycles, load_direct,
      output pi_ctl_out, settled, busy
   );
endinterface
`default_nettype wire

// File: rtl/pi_ctl_slew_limiter.sv
`default_nettype none
// ============================================================================
// Module      : pi_ctl_slew_limiter
// Description : Per-channel rate limiter for PI control codes using
//               shortest-path modular stepping with a programmable hold.
// Revision    : 1.0 - initial release
// ============================================================================
module pi_ctl_slew_limiter #(
   parameter int NPI   = 9,
   parameter int NOUT  = 4,
   parameter int NHOLD = 4
) (
   input  wire logic               clk_adc,
   input  wire logic               rstb,
   pi_ctl_slew_limiter_if.slave    bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   localparam logic [NPI-1:0]   C_ZERO     = '0;
   localparam logic [NPI-1:0]   C_ONE      = NPI'(1);
   localparam logic [NPI-1:0]   C_HALF     = {1'b1, {(NPI-1){1'b0}}};
   localparam logic [NHOLD-1:0] C_HOLD_ONE = NHOLD'(1);

   logic [NPI-1:0]  w_eff_step;
   logic            w_bypass;
   logic [NOUT-1:0] w_settled;

   // A programmed step of zero would stall the channel forever.
   assign w_eff_step = (bus.max_step == C_ZERO) ? C_ONE : bus.max_step;
   assign w_bypass   = ~bus.en_limit | bus.load_direct;

   for (genvar j = 0; j < NOUT; j++) begin : g_ch
      logic [NPI-1:0]   r_cur;
      logic [NHOLD-1:0] r_hold;
      logic [NPI-1:0]   w_diff;
      logic             w_up;
      logic [NPI-1:0]   w_mag;
      logic [NPI-1:0]   w_step;
      state_t           w_state;

      assign w_diff = bus.pi_ctl_target[j] - r_cur;
      // Half-circle tie resolves upward.
      assign w_up   = (w_diff <= C_HALF);
      assign w_mag  = w_up ? w_diff : (C_ZERO - w_diff);
      assign w_step = (w_mag < w_eff_step) ? w_mag : w_eff_step;

      always_comb begin
         w_state = ST_IDLE;
         if (r_hold != '0) begin
            w_state = ST_HOLD;
         end else if (w_diff != C_ZERO) begin
            w_state = ST_STEP;
         end
      end

      always_ff @(posedge clk_adc or negedge rstb) begin
         if (!rstb) begin
            r_cur  <= '0;
            r_hold <= '0;
         end else if (w_bypass) begin
            r_cur  <= bus.pi_ctl_target[j];
            r_hold <= '0;
         end else begin
            case (w_state)
               ST_STEP: begin
                  r_cur  <= w_up ? (r_cur + w_step) : (r_cur - w_step);
                  r_hold <= bus.hold_cycles;
               end
               ST_HOLD: begin
                  r_hold <= r_hold - C_HOLD_ONE;
               end
               default: begin
                  r_cur  <= r_cur;
                  r_hold <= r_hold;
               end
            endcase
         end
      end

      assign bus.pi_ctl_out[j] = r_cur;
      assign w_settled[j]      = (w_diff == C_ZERO);
   end

   assign bus.settled = w_settled;
   assign bus.busy    = ~&w_settled;

endmodule
`default_nettype wire

// File: tb/tb_pi_ctl_slew_limiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pi_ctl_slew_limiter
// Description : Directed and randomized bench for pi_ctl_slew_limiter with an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pi_ctl_slew_limiter;

   localparam int NPI   = 9;
   localparam int NOUT  = 4;
   localparam int NHOLD = 4;
   localparam int MOD   = 1 << NPI;

   logic clk_adc;
   logic rstb;

   pi_ctl_slew_limiter_if #(.NPI(NPI), .NOUT(NOUT), .NHOLD(NHOLD)) bus ();

   pi_ctl_slew_limiter #(.NPI(NPI), .NOUT(NOUT), .NHOLD(NHOLD)) dut (
      .clk_adc (clk_adc),
      .rstb    (rstb),
      .bus     (bus.slave)
   );

   initial clk_adc = 1'b0;
   always #5 clk_adc = ~clk_adc;

   int n_cmp;
   int n_mis;
   int m_cur  [NOUT];
   int m_hold [NOUT];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < NOUT; j++) begin
         m_cur[j]  = 0;
         m_hold[j] = 0;
      end
   endtask

   // Shortest-path mover on a circle of MOD codes.
   task automatic model_clock();
      int t, d, eff, mv;
      eff = (int'(bus.max_step) == 0) ? 1 : int'(bus.max_step);
      for (int j = 0; j < NOUT; j++) begin
         t = int'(bus.pi_ctl_target[j]);
         if (!bus.en_limit || bus.load_direct) begin
            m_cur[j]  = t;
            m_hold[j] = 0;
         end else if (m_hold[j] > 0) begin
            m_hold[j] = m_hold[j] - 1;
         end else if (t != m_cur[j]) begin
            d = (t - m_cur[j] + MOD) % MOD;
            if (d <= MOD / 2) begin
               mv = (d < eff) ? d : eff;
               m_cur[j] = (m_cur[j] + mv) % MOD;
            end else begin
               mv = ((MOD - d) < eff) ? (MOD - d) : eff;
               m_cur[j] = (m_cur[j] - mv + MOD) % MOD;
            end
            m_hold[j] = int'(bus.hold_cycles);
         end
      end
   endtask

   task automatic check_all();
      int nset;
      nset = 0;
      for (int j = 0; j < NOUT; j++) begin
         check($sformatf("out%0d", j), 32'(bus.pi_ctl_out[j]), 32'(m_cur[j]));
         check($sformatf("settled%0d", j), 32'(bus.settled[j]),
               32'(m_cur[j] == int'(bus.pi_ctl_target[j])));
         if (m_cur[j] == int'(bus.pi_ctl_target[j])) nset++;
      end
      check("busy", 32'(bus.busy), 32'(nset != NOUT));
   endtask

   task automatic cyc();
      @(posedge clk_adc);
      model_clock();
      #1;
      check_all();
   endtask

   task automatic set_targets(input int a, input int b, input int c, input int d);
      bus.pi_ctl_target[0] = NPI'(a);
      bus.pi_ctl_target[1] = NPI'(b);
      bus.pi_ctl_target[2] = NPI'(c);
      bus.pi_ctl_target[3] = NPI'(d);
   endtask

   initial begin
      n_cmp = 0;
      n_mis = 0;
      model_reset();
      rstb            = 1'b0;
      bus.en_limit    = 1'b1;
      bus.load_direct = 1'b0;
      bus.max_step    = '0;
      bus.hold_cycles = '0;
      set_targets(0, 0, 0, 0);

      // Reset state
      repeat (2) @(posedge clk_adc);
      #1;
      check("rst_out0", 32'(bus.pi_ctl_out[0]), 32'd0);
      check("rst_settled", 32'(bus.settled), 32'hF);
      check("rst_busy", 32'(bus.busy), 32'd0);
      @(negedge clk_adc);
      rstb = 1'b1;

      // Slew up in steps of 8
      bus.max_step = 9'd8;
      bus.hold_cycles = '0;
      bus.pi_ctl_target[0] = 9'd40;
      for (int k = 1; k <= 5; k++) begin
         cyc();
         check("slew_up", 32'(bus.pi_ctl_out[0]), 32'(8 * k));
      end
      check("slew_up_settled", 32'(bus.settled[0]), 32'd1);
      check("slew_up_busy", 32'(bus.busy), 32'd0);

      // Hold interval of 3 cycles between steps
      bus.en_limit = 1'b0;
      bus.pi_ctl_target[0] = 9'd0;
      cyc();
      bus.en_limit = 1'b1;
      bus.hold_cycles = 4'd3;
      bus.pi_ctl_target[0] = 9'd20;
      for (int c = 1; c <= 9; c++) begin
         cyc();
         check("hold", 32'(bus.pi_ctl_out[0]), (c < 5) ? 32'd8 : (c < 9) ? 32'd16 : 32'd20);
      end

      // Wrap paths with step 2
      bus.max_step = 9'd2;
      bus.hold_cycles = '0;
      bus.en_limit = 1'b0;
      bus.pi_ctl_target[0] = 9'd510;
      cyc();
      bus.en_limit = 1'b1;
      bus.pi_ctl_target[0] = 9'd3;
      cyc(); check("wrap_up_a", 32'(bus.pi_ctl_out[0]), 32'd0);
      cyc(); check("wrap_up_b", 32'(bus.pi_ctl_out[0]), 32'd2);
      cyc(); check("wrap_up_c", 32'(bus.pi_ctl_out[0]), 32'd3);
      bus.pi_ctl_target[0] = 9'd510;
      cyc(); check("wrap_dn_a", 32'(bus.pi_ctl_out[0]), 32'd1);
      cyc(); check("wrap_dn_b", 32'(bus.pi_ctl_out[0]), 32'd511);
      cyc(); check("wrap_dn_c", 32'(bus.pi_ctl_out[0]), 32'd510);
      bus.en_limit = 1'b0;
      bus.pi_ctl_target[0] = 9'd0;
      cyc();
      bus.en_limit = 1'b1;
      bus.pi_ctl_target[0] = 9'd256;
      cyc(); check("tie_a", 32'(bus.pi_ctl_out[0]), 32'd2);
      cyc(); check("tie_b", 32'(bus.pi_ctl_out[0]), 32'd4);

      // Bypass: one-cycle latency
      bus.en_limit = 1'b0;
      bus.pi_ctl_target[0] = 9'd0;
      cyc();
      bus.pi_ctl_target[0] = 9'd300;
      cyc(); check("bypass", 32'(bus.pi_ctl_out[0]), 32'd300);

      // Direct load mid-slew, then an immediate step proves cleared holds
      bus.en_limit = 1'b1;
      bus.max_step = 9'd1;
      bus.hold_cycles = 4'd2;
      set_targets(100, 200, 300, 400);
      repeat (3) cyc();
      bus.load_direct = 1'b1;
      cyc();
      bus.load_direct = 1'b0;
      for (int j = 0; j < NOUT; j++)
         check($sformatf("load_ch%0d", j), 32'(bus.pi_ctl_out[j]), 32'(bus.pi_ctl_target[j]));
      bus.pi_ctl_target[0] = 9'd105;
      cyc(); check("load_hold0", 32'(bus.pi_ctl_out[0]), 32'd101);

      // Step 0 acts as 1; reversal without overshoot
      bus.max_step = '0;
      bus.hold_cycles = '0;
      bus.en_limit = 1'b0;
      set_targets(0, 77, 300, 400);
      cyc();
      bus.en_limit = 1'b1;
      bus.pi_ctl_target[0] = 9'd100;
      for (int k = 1; k <= 12; k++) begin
         cyc(); check("step0", 32'(bus.pi_ctl_out[0]), 32'(k));
      end
      bus.pi_ctl_target[0] = 9'd5;
      for (int k = 11; k >= 5; k--) begin
         cyc(); check("reverse", 32'(bus.pi_ctl_out[0]), 32'(k));
      end
      check("other_ch", 32'(bus.pi_ctl_out[1]), 32'd77);

      // Asynchronous reset mid-slew
      bus.max_step = 9'd1;
      set_targets(200, 150, 50, 450);
      repeat (3) cyc();
      #3;
      rstb = 1'b0;
      #1;
      for (int j = 0; j < NOUT; j++)
         check($sformatf("async_rst%0d", j), 32'(bus.pi_ctl_out[j]), 32'd0);
      model_reset();
      @(negedge clk_adc);
      rstb = 1'b1;

      // Randomized traffic
      for (int n = 0; n < 2000; n++) begin
         for (int j = 0; j < NOUT; j++)
            if ($urandom_range(0, 9) == 0) bus.pi_ctl_target[j] = NPI'($urandom_range(0, MOD - 1));
         if ($urandom_range(0, 19) == 0) bus.max_step = NPI'($urandom_range(0, 40));
         if ($urandom_range(0, 19) == 0) bus.hold_cycles = NHOLD'($urandom_range(0, 3));
         bus.en_limit    = ($urandom_range(0, 19) != 0);
         bus.load_direct = ($urandom_range(0, 49) == 0);
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
